// File: rtl/trap_sequencer_if.sv
// Trap sequencer bundle: pipeline trap/MRET requests, the CSR port and the redirect/stall outputs.
// The sequencer takes the slave modport; the pipeline/CSR side takes the master modport.
interface trap_sequencer_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  logic               exc_valid;
  logic [4:0]         exc_cause;
  logic [XLEN-1:0]    exc_pc;
  logic [XLEN-1:0]    exc_tval;
  logic               mret_req;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [XLEN-1:0]    irq_pc;
  logic               mstatus_mie;
  logic [XLEN-1:0]    csr_read_data;
  logic               csr_we;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wdata;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               flush;
  logic               busy;

  modport master (
    output exc_valid, exc_cause, exc_pc, exc_tval, mret_req, irq_pending, irq_pc,
           mstatus_mie, csr_read_data,
    input  csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, busy
  );

  modport slave (
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret_req, irq_pending, irq_pc,
           mstatus_mie, csr_read_data,
    output csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, busy
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap/MRET sequencer: walks mepc/mcause/(mtval)/mstatus writes through one CSR port, then redirects.
// Optional macro TRAP_SEQ_MTVAL_EN adds the WR_MTVAL state so mtval is written on every trap.
module trap_sequencer #(
  parameter int XLEN           = 32,
  parameter int NUM_IRQ        = 4,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input logic             clk,
  input logic             reset,
  input logic             clk_enable,
  trap_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_MEPC   = 3'd1,
    WR_MCAUSE = 3'd2,
    WR_MTVAL  = 3'd3,
    WR_MSTAT  = 3'd4,
    RD_MTVEC  = 3'd5,
    RET_MSTAT = 3'd6,
    RET_MEPC  = 3'd7
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [4:0]      code_r;
  logic            is_irq_r;
  logic            csr_we_r;
  logic [11:0]     csr_addr_r;
  logic [XLEN-1:0] wdata_r;
  logic            redirect_r;
  logic            busy_r;
`ifdef TRAP_SEQ_MTVAL_EN
  logic [XLEN-1:0] tval_r;
`endif

  logic            irq_take_s;
  logic [4:0]      irq_idx_s;
  logic [XLEN-1:0] trap_pc_s;
  logic [4:0]      trap_code_s;
  logic            trap_irq_s;
  logic            accept_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] rd_base_s;
  logic [XLEN-1:0] redirect_pc_s;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= machine.
  function automatic logic [XLEN-1:0] mstat_trap(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r        = v;
    r[7]     = v[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // MRET: MIE <= MPIE, MPIE <= 1.
  function automatic logic [XLEN-1:0] mstat_ret(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r    = v;
    r[3] = v[7];
    r[7] = 1'b1;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mcause_of(input logic irq, input logic [4:0] code);
    return {irq, {(XLEN-6){1'b0}}, code};
  endfunction

  // Lowest pending interrupt index wins.
  always_comb begin
    irq_idx_s = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (bus.irq_pending[i]) begin
        irq_idx_s = 5'(i);
      end else begin
        irq_idx_s = irq_idx_s;
      end
    end
  end

  // Request arbitration in IDLE: exception > MRET > enabled interrupt.
  always_comb begin
    irq_take_s = bus.mstatus_mie && (|bus.irq_pending);
    if (bus.exc_valid) begin
      trap_pc_s   = bus.exc_pc;
      trap_code_s = bus.exc_cause;
      trap_irq_s  = 1'b0;
    end else begin
      trap_pc_s   = bus.irq_pc;
      trap_code_s = 5'(IRQ_CAUSE_BASE) + irq_idx_s;
      trap_irq_s  = 1'b1;
    end
    accept_s = (state_r == IDLE) && clk_enable &&
               (bus.exc_valid || bus.mret_req || irq_take_s);
  end

  // Sequencer state, latched trap context and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      pc_r       <= {XLEN{1'b0}};
      code_r     <= 5'd0;
      is_irq_r   <= 1'b0;
      csr_we_r   <= 1'b0;
      csr_addr_r <= 12'h000;
      wdata_r    <= {XLEN{1'b0}};
      redirect_r <= 1'b0;
      busy_r     <= 1'b0;
`ifdef TRAP_SEQ_MTVAL_EN
      tval_r     <= {XLEN{1'b0}};
`endif
    end else if (clk_enable) begin
      case (state_r)
        IDLE: begin
          if (bus.exc_valid || (!bus.mret_req && irq_take_s)) begin
            state_r    <= WR_MEPC;
            pc_r       <= trap_pc_s;
            code_r     <= trap_code_s;
            is_irq_r   <= trap_irq_s;
            csr_we_r   <= 1'b1;
            csr_addr_r <= CSR_MEPC;
            wdata_r    <= {trap_pc_s[XLEN-1:2], 2'b00};
            redirect_r <= 1'b0;
            busy_r     <= 1'b1;
`ifdef TRAP_SEQ_MTVAL_EN
            tval_r     <= bus.exc_valid ? bus.exc_tval : {XLEN{1'b0}};
`endif
          end else if (bus.mret_req) begin
            state_r    <= RET_MSTAT;
            csr_we_r   <= 1'b1;
            csr_addr_r <= CSR_MSTATUS;
            wdata_r    <= {XLEN{1'b0}};
            redirect_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
            csr_we_r   <= 1'b0;
            csr_addr_r <= 12'h000;
            wdata_r    <= {XLEN{1'b0}};
            redirect_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        WR_MEPC: begin
          state_r    <= WR_MCAUSE;
          csr_addr_r <= CSR_MCAUSE;
          wdata_r    <= mcause_of(is_irq_r, code_r);
        end
`ifdef TRAP_SEQ_MTVAL_EN
        WR_MCAUSE: begin
          state_r    <= WR_MTVAL;
          csr_addr_r <= CSR_MTVAL;
          wdata_r    <= tval_r;
        end
        WR_MTVAL: begin
          state_r    <= WR_MSTAT;
          csr_addr_r <= CSR_MSTATUS;
          wdata_r    <= {XLEN{1'b0}};
        end
`else
        WR_MCAUSE: begin
          state_r    <= WR_MSTAT;
          csr_addr_r <= CSR_MSTATUS;
          wdata_r    <= {XLEN{1'b0}};
        end
`endif
        WR_MSTAT: begin
          state_r    <= RD_MTVEC;
          csr_we_r   <= 1'b0;
          csr_addr_r <= CSR_MTVEC;
          redirect_r <= 1'b1;
        end
        RET_MSTAT: begin
          state_r    <= RET_MEPC;
          csr_we_r   <= 1'b0;
          csr_addr_r <= CSR_MEPC;
          redirect_r <= 1'b1;
        end
        default: begin
          // RD_MTVEC, RET_MEPC and any unencoded state all fall back to IDLE.
          state_r    <= IDLE;
          csr_we_r   <= 1'b0;
          csr_addr_r <= 12'h000;
          wdata_r    <= {XLEN{1'b0}};
          redirect_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // mstatus read-modify-write data follows the combinational CSR read in the same cycle.
  always_comb begin
    case (state_r)
      WR_MSTAT:  wdata_s = mstat_trap(bus.csr_read_data);
      RET_MSTAT: wdata_s = mstat_ret(bus.csr_read_data);
      default:   wdata_s = wdata_r;
    endcase
  end

  // Redirect target: vectored mtvec only for interrupts; offset wraps mod 2^XLEN.
  always_comb begin
    rd_base_s = {bus.csr_read_data[XLEN-1:2], 2'b00};
    case (state_r)
      RD_MTVEC: begin
        if ((bus.csr_read_data[1:0] == 2'b01) && is_irq_r) begin
          redirect_pc_s = rd_base_s + (XLEN'(code_r) << 2);
        end else begin
          redirect_pc_s = rd_base_s;
        end
      end
      RET_MEPC: redirect_pc_s = rd_base_s;
      default:  redirect_pc_s = {XLEN{1'b0}};
    endcase
  end

  assign bus.csr_we         = csr_we_r;
  assign bus.csr_addr       = csr_addr_r;
  assign bus.csr_wdata      = wdata_s;
  assign bus.redirect_valid = redirect_r;
  assign bus.flush          = redirect_r;
  assign bus.redirect_pc    = redirect_pc_s;
  assign bus.busy           = busy_r | accept_s;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: table vectors, hand sequences (reset abort, clk_enable stall) and random traffic
// against a spec-level model of the CSR effects, redirect target and latency.
module tb_trap_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic clk_enable;
  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(32), .NUM_IRQ(4)) bus ();

  trap_sequencer #(.XLEN(32), .NUM_IRQ(4), .IRQ_CAUSE_BASE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

`ifdef TRAP_SEQ_MTVAL_EN
  localparam int TRAP_LAT = 5;
`else
  localparam int TRAP_LAT = 4;
`endif
  localparam int MRET_LAT = 2;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural CSR file beside the sequencer; the bench preloads it through tb_we.
  logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q, mtval_q;
  int          wr_total, wr_mtval;
  logic        tb_we;
  logic [11:0] tb_addr;
  logic [31:0] tb_data;

  always_comb begin
    case (bus.csr_addr)
      12'h300: bus.csr_read_data = mstatus_q;
      12'h305: bus.csr_read_data = mtvec_q;
      12'h341: bus.csr_read_data = mepc_q;
      12'h342: bus.csr_read_data = mcause_q;
      12'h343: bus.csr_read_data = mtval_q;
      default: bus.csr_read_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (tb_we) begin
      case (tb_addr)
        12'h300: mstatus_q <= tb_data;
        12'h305: mtvec_q   <= tb_data;
        12'h341: mepc_q    <= tb_data;
        default: mcause_q  <= tb_data;
      endcase
    end else if (!reset && clk_enable && bus.csr_we) begin
      wr_total <= wr_total + 1;
      case (bus.csr_addr)
        12'h300: mstatus_q <= bus.csr_wdata;
        12'h305: mtvec_q   <= bus.csr_wdata;
        12'h341: mepc_q    <= bus.csr_wdata;
        12'h342: mcause_q  <= bus.csr_wdata;
        12'h343: begin mtval_q <= bus.csr_wdata; wr_mtval <= wr_mtval + 1; end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.exc_valid = 1'b0; bus.exc_cause = 5'd0; bus.exc_pc = 32'h0; bus.exc_tval = 32'h0;
    bus.mret_req = 1'b0; bus.irq_pending = 4'b0; bus.irq_pc = 32'h0; bus.mstatus_mie = 1'b0;
  endtask

  // One request; the model decides trap/MRET/none from priority rules and checks CSR effects.
  task automatic do_txn(input logic e, input logic [4:0] c, input logic [31:0] p, input logic [31:0] t,
                        input logic m, input logic [3:0] iq, input logic [31:0] ip, input logic mi,
                        input logic hold, output logic [31:0] got_pc);
    logic        acc, trap, irq;
    logic [4:0]  code;
    logic [31:0] tpc, ms0, tv0, ep0, mc0, exp_pc, exp_ms, exp_tval;
    int          exp_lat, got_lat, w0, wt0;
    ms0 = mstatus_q; tv0 = mtvec_q; ep0 = mepc_q; mc0 = mcause_q; w0 = wr_total; wt0 = wr_mtval;
    trap = 1'b0; irq = 1'b0; code = 5'd0; tpc = 32'h0; exp_tval = 32'h0;
    if (e) begin
      trap = 1'b1; code = c; tpc = p; exp_tval = t;
    end else if (!m && mi && iq != 4'b0) begin
      trap = 1'b1; irq = 1'b1; tpc = ip;
      for (int i = 3; i >= 0; i--) if (iq[i]) code = 5'(16 + i);
    end
    acc = e || m || (mi && iq != 4'b0);
    exp_pc = 32'h0; exp_ms = ms0; exp_lat = 0;
    if (trap) begin
      exp_lat = TRAP_LAT;
      exp_pc  = (tv0 & ~32'h3) + ((irq && tv0[1:0] == 2'd1) ? 32'd4 * code : 32'd0);
      exp_ms  = (ms0 & ~32'h0000_1888) | 32'h0000_1800 | (ms0[3] ? 32'h80 : 32'h0);
    end else if (acc) begin
      exp_lat = MRET_LAT;
      exp_pc  = ep0 & ~32'h3;
      exp_ms  = (ms0 & ~32'h0000_0008) | 32'h80 | (ms0[7] ? 32'h8 : 32'h0);
    end

    @(negedge clk);
    bus.exc_valid = e; bus.exc_cause = c; bus.exc_pc = p; bus.exc_tval = t;
    bus.mret_req = m; bus.irq_pending = iq; bus.irq_pc = ip; bus.mstatus_mie = mi;
    #1;
    check("busy_in_accept_cycle", {31'b0, bus.busy}, {31'b0, acc});
    @(posedge clk); #1;
    if (!hold || !acc) clear_inputs();
    got_pc = 32'h0; got_lat = 0;
    if (acc) begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (bus.redirect_valid) begin
          got_lat = k; got_pc = bus.redirect_pc;
          check("flush_with_redirect", {31'b0, bus.flush}, 32'd1);
          break;
        end
      end
      clear_inputs();
      check("redirect_latency", got_lat, exp_lat);
      check("redirect_pc", got_pc, exp_pc);
      @(negedge clk);
      check("busy_after_redirect", {31'b0, bus.busy}, 32'd0);
      check("redirect_one_shot", {31'b0, bus.redirect_valid}, 32'd0);
      check("mstatus_after", mstatus_q, exp_ms);
      if (trap) begin
        check("mepc_after", mepc_q, tpc & ~32'h3);
        check("mcause_after", mcause_q, {irq, 26'b0, code});
`ifdef TRAP_SEQ_MTVAL_EN
        check("mtval_after", mtval_q, exp_tval);
        check("mtval_writes", wr_mtval - wt0, 32'd1);
`else
        check("mtval_writes", wr_mtval - wt0, 32'd0);
`endif
      end else begin
        check("mcause_untouched", mcause_q, mc0);
        check("mret_write_count", wr_total - w0, 32'd1);
      end
    end else begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        check("idle_no_redirect", {30'b0, bus.redirect_valid, bus.busy}, 32'd0);
      end
      check("idle_no_writes", wr_total - w0, 32'd0);
    end
  endtask

  typedef struct {
    logic e; logic [4:0] c; logic [31:0] p; logic m; logic [3:0] iq; logic [31:0] ip; logic mi;
    logic [31:0] mtvec; logic [31:0] mstatus; logic [31:0] mepc; logic hold;
    logic [31:0] exp_pc; logic [31:0] exp_mcause; logic [31:0] exp_mstatus;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] gpc, held_pc;
  int          w0;

  initial begin
    vecs[0] = '{1'b1, 5'd11, 32'h100,  1'b0, 4'b0000, 32'h0,  1'b0, 32'h200, 32'h8,
                32'h0, 1'b0, 32'h200, 32'd11, 32'h1880};
    vecs[1] = '{1'b0, 5'd0,  32'h0,    1'b0, 4'b0110, 32'h80, 1'b1, 32'h301, 32'h8,
                32'h0, 1'b0, 32'h344, 32'h8000_0011, 32'h1880};
    vecs[2] = '{1'b1, 5'd2,  32'h204,  1'b1, 4'b0001, 32'h40, 1'b1, 32'h301, 32'h0,
                32'h0, 1'b1, 32'h300, 32'd2, 32'h1800};
    vecs[3] = '{1'b0, 5'd0,  32'h0,    1'b1, 4'b0000, 32'h0,  1'b0, 32'h200, 32'h80,
                32'h103, 1'b0, 32'h100, 32'd2, 32'h88};
    vecs[4] = '{1'b1, 5'd4,  32'h1007, 1'b0, 4'b0000, 32'h0,  1'b0, 32'h1001, 32'h1888,
                32'h0, 1'b0, 32'h1000, 32'd4, 32'h1880};
    vecs[5] = '{1'b0, 5'd0,  32'h0,    1'b0, 4'b1000, 32'h44, 1'b1, 32'hFFFF_FFF1, 32'h0,
                32'h0, 1'b0, 32'h3C, 32'h8000_0013, 32'h1800};
    vecs[6] = '{1'b0, 5'd0,  32'h0,    1'b0, 4'b1111, 32'h44, 1'b0, 32'h200, 32'h8,
                32'h0, 1'b0, 32'h0, 32'h8000_0013, 32'h8};

    tb_we = 1'b0; tb_addr = 12'h0; tb_data = 32'h0;
    mstatus_q = 32'h0; mtvec_q = 32'h0; mepc_q = 32'h0; mcause_q = 32'h0; mtval_q = 32'h0;
    wr_total = 0; wr_mtval = 0;
    clear_inputs();
    clk_enable = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_csr_we", {31'b0, bus.csr_we}, 32'd0);
    check("reset_csr_addr", {20'b0, bus.csr_addr}, 32'd0);
    check("reset_csr_wdata", bus.csr_wdata, 32'd0);
    check("reset_redirect", {30'b0, bus.redirect_valid, bus.flush}, 32'd0);
    check("reset_redirect_pc", bus.redirect_pc, 32'd0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      set_csr(12'h305, vecs[i].mtvec);
      set_csr(12'h300, vecs[i].mstatus);
      if (vecs[i].m) set_csr(12'h341, vecs[i].mepc);
      do_txn(vecs[i].e, vecs[i].c, vecs[i].p, 32'h1003, vecs[i].m, vecs[i].iq, vecs[i].ip,
             vecs[i].mi, vecs[i].hold, gpc);
      if (i != 6) check($sformatf("vec%0d_redirect_pc", i), gpc, vecs[i].exp_pc);
      check($sformatf("vec%0d_mcause", i), mcause_q, vecs[i].exp_mcause);
      check($sformatf("vec%0d_mstatus", i), mstatus_q, vecs[i].exp_mstatus);
    end

    // Reset while WR_MCAUSE is on the port aborts the sequence.
    set_csr(12'h305, 32'h200);
    @(negedge clk);
    bus.exc_valid = 1'b1; bus.exc_cause = 5'd11; bus.exc_pc = 32'h500;
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    check("abort_in_mcause", {20'b0, bus.csr_addr}, 32'h342);
    w0 = wr_total;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_csr_we", {31'b0, bus.csr_we}, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_redirect", {31'b0, bus.redirect_valid}, 32'd0);
    end
    check("abort_no_writes", wr_total - w0, 32'd0);

    // clk_enable low holds WR_MSTAT, then holds and repeats the redirect.
    set_csr(12'h300, 32'h8);
    @(negedge clk);
    bus.exc_valid = 1'b1; bus.exc_cause = 5'd4; bus.exc_pc = 32'h600; bus.exc_tval = 32'h1003;
    @(posedge clk); #1;
    clear_inputs();
    repeat (TRAP_LAT - 1) @(negedge clk);
    check("stall_at_mstat", {20'b0, bus.csr_addr}, 32'h300);
    clk_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_hold_addr", {20'b0, bus.csr_addr}, 32'h300);
      check("stall_hold_busy", {31'b0, bus.busy}, 32'd1);
    end
    check("stall_mstatus_unwritten", mstatus_q, 32'h8);
    clk_enable = 1'b1;
    @(negedge clk);
    check("stall_redirect", {31'b0, bus.redirect_valid}, 32'd1);
    held_pc = bus.redirect_pc;
    clk_enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_redirect_repeat", {31'b0, bus.redirect_valid}, 32'd1);
      check("stall_redirect_pc", bus.redirect_pc, 32'h200);
    end
    check("stall_redirect_pc_first", held_pc, 32'h200);
    clk_enable = 1'b1;
    @(negedge clk);
    check("stall_release_idle", {30'b0, bus.redirect_valid, bus.busy}, 32'd0);
    check("stall_mstatus", mstatus_q, 32'h1880);
    check("stall_mepc", mepc_q, 32'h600);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      set_csr(12'h305, {$urandom()} & 32'hFFFF_FFFD);
      set_csr(12'h300, $urandom());
      set_csr(12'h341, $urandom());
      do_txn($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), $urandom(), $urandom(),
             $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom(),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, gpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
